// File: rtl/mcu_subsys_mem_loader.sv
// mcu_subsys_mem_loader: packs a byte stream into SRAM words, reads the region back and checks its byte sum
module mcu_subsys_mem_loader #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] len,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_rdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      checksum
);
  typedef enum logic [2:0] {IDLE, COLLECT, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE} state_t;
  state_t           state;
  logic [31:0]      base, rsum, rd_add;
  logic [LEN_W-1:0] len_r, cnt, rd_rem;
  logic             last_byte;
  assign last_byte = cnt == len_r - LEN_W'(1);
  // byte sum of only those lanes that were written for the word being read back
  always_comb begin
    rd_add = '0;
    for (int i = 0; i < 4; i++)
      rd_add = rd_add + ((rd_rem > LEN_W'(i)) ? {24'd0, mem_rdata[8*i +: 8]} : 32'd0);
  end
  // transfer sequencer: collect a word, write it, then read every word back and compare sums
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base      <= '0;
      len_r     <= '0;
      cnt       <= '0;
      rd_rem    <= '0;
      rsum      <= '0;
      s_ready   <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      checksum  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          base      <= base_addr & ~32'd3;
          mem_addr  <= base_addr & ~32'd3;
          len_r     <= len;
          cnt       <= '0;
          rsum      <= '0;
          checksum  <= '0;
          err       <= 1'b0;
          mem_wdata <= '0;
          mem_wstrb <= '0;
          busy      <= 1'b1;
          if (len == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            s_ready <= 1'b1;
            state   <= COLLECT;
          end
        end
        COLLECT: if (s_valid) begin
          mem_wdata[{cnt[1:0], 3'b000} +: 8] <= s_data;
          mem_wstrb[cnt[1:0]]                <= 1'b1;
          checksum                           <= checksum + {24'd0, s_data};
          cnt                                <= cnt + LEN_W'(1);
          if (cnt[1:0] == 2'd3 || last_byte) begin
            s_ready   <= 1'b0;
            mem_valid <= 1'b1;
            state     <= WR_REQ;
          end
        end
        WR_REQ: if (mem_ready) begin
          mem_valid <= 1'b0;
          state     <= WR_GAP;
        end
        WR_GAP: begin
          mem_wdata <= '0;
          mem_wstrb <= '0;
          if (cnt != len_r) begin
            mem_addr <= mem_addr + 32'd4;
            s_ready  <= 1'b1;
            state    <= COLLECT;
          end else begin
            mem_addr  <= base;
            rd_rem    <= len_r;
            mem_valid <= 1'b1;
            state     <= RD_REQ;
          end
        end
        RD_REQ: if (mem_ready) begin
          rsum      <= rsum + rd_add;
          rd_rem    <= (rd_rem > LEN_W'(4)) ? rd_rem - LEN_W'(4) : '0;
          mem_valid <= 1'b0;
          state     <= RD_GAP;
        end
        RD_GAP: if (rd_rem != '0) begin
          mem_addr  <= mem_addr + 32'd4;
          mem_valid <= 1'b1;
          state     <= RD_REQ;
        end else begin
          done  <= 1'b1;
          err   <= rsum != checksum;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mcu_subsys_mem_loader.sv
// tb_mcu_subsys_mem_loader: randomized stream/responder bench with a transaction-level model of the loader
module tb_mcu_subsys_mem_loader;
  localparam int LEN_W = 16;
  logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0]      base_addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic             s_valid = 1'b0;
  logic [7:0]       s_data = '0;
  logic             s_ready, mem_valid;
  logic             mem_ready = 1'b0;
  logic [31:0]      mem_addr, mem_wdata;
  logic [31:0]      mem_rdata = '0;
  logic [3:0]       mem_wstrb;
  logic             busy, done, err;
  logic [31:0]      checksum;

  mcu_subsys_mem_loader #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err(err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  txn_t        eq[$];
  logic [7:0]  bq[$], src[$];
  logic [31:0] mem [logic [29:0]];
  int          vecs = 0, fails = 0;
  int          wait_st = 0, pct = 100, done_cnt = 0, wc = 0;
  bit          stale, pcomp, pv, mv_seen, sr_seen, corrupt_en, noise, exp_err;
  logic [31:0] pa, pd, corrupt_addr, exp_ck;
  logic [3:0]  ps;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a[31:2]) ? mem[a[31:2]] : 32'd0;
  endfunction

  // responder side of one completing request: check against model, update SRAM, present read data
  task automatic serve();
    txn_t        e;
    logic [31:0] cur;
    chk("req_expected", 32'(eq.size() != 0), 32'd1);
    mem_rdata = $urandom;
    if (eq.size() != 0) begin
      e = eq.pop_front();
      chk("req_kind", 32'(mem_wstrb != 4'd0), 32'(e.we));
      chk("req_addr", mem_addr, e.addr);
      if (e.we) begin
        chk("wr_data", mem_wdata, e.wdata);
        chk("wr_strb", 32'(mem_wstrb), 32'(e.wstrb));
        cur = rd_mem(mem_addr);
        for (int j = 0; j < 4; j++)
          if (mem_wstrb[j]) cur[8*j +: 8] = mem_wdata[8*j +: 8];
        mem[mem_addr[31:2]] = cur;
      end else begin
        chk("rd_strb", 32'(mem_wstrb), 32'd0);
        mem_rdata = rd_mem(mem_addr) ^ ((corrupt_en && mem_addr == corrupt_addr) ? 32'd1 : 32'd0);
      end
    end
  endtask

  // per-cycle compare, SRAM responder with sticky ready, and stream source
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      stale = 0; pcomp = 0; pv = 0; wc = 0;
      mem_ready = 1'b0;
      s_valid = 1'b0;
      continue;
    end
    if (pv && !pcomp) begin
      chk("hold_valid", 32'(mem_valid), 32'd1);
      if (mem_valid) begin
        chk("hold_addr", mem_addr, pa);
        chk("hold_wdata", mem_wdata, pd);
        chk("hold_wstrb", 32'(mem_wstrb), 32'(ps));
      end
    end
    if (pcomp) chk("gap", 32'(mem_valid), 32'd0);
    chk("sready_excl", 32'(s_ready && mem_valid), 32'd0);
    if (mem_valid) begin
      mv_seen = 1;
      chk("addr_align", 32'(mem_addr[1:0]), 32'd0);
    end
    if (s_ready) sr_seen = 1;
    if (done) begin
      done_cnt++;
      chk("checksum", checksum, exp_ck);
      chk("err", 32'(err), 32'(exp_err));
    end
    pv = mem_valid; pa = mem_addr; pd = mem_wdata; ps = mem_wstrb; pcomp = 0;
    if (stale) begin
      mem_ready = 1'b1; stale = 0; mem_rdata = $urandom;
    end else if (mem_valid && wc < wait_st) begin
      wc++; mem_ready = 1'b0; mem_rdata = $urandom;
    end else if (mem_valid) begin
      wc = 0; mem_ready = 1'b1; pcomp = 1; stale = 1;
      serve();
    end else begin
      mem_ready = 1'b0;
    end
    if (bq.size() > 0 && s_ready && $urandom_range(99) < pct) begin
      s_valid = 1'b1;
      s_data  = bq.pop_front();
    end else begin
      s_valid = 1'($urandom_range(1)) & ~s_ready;
      s_data  = 8'($urandom);
    end
  end

  // build the expected bus transactions and sums for src, then issue start
  task automatic kick(input logic [31:0] b, input int n, input int w, input int p);
    logic [31:0] wd, a;
    logic [3:0]  st;
    int          nw;
    exp_ck = 0; exp_err = 0; eq.delete();
    nw = (n + 3) / 4;
    for (int k = 0; k < n; k++) exp_ck += 32'(src[k]);
    for (int i = 0; i < nw; i++) begin
      wd = 0; st = 0;
      for (int j = 0; j < 4; j++)
        if (4*i + j < n) begin
          wd[8*j +: 8] = src[4*i + j];
          st[j] = 1'b1;
        end
      eq.push_back('{1'b1, (b & ~32'd3) + 32'(4*i), wd, st});
    end
    for (int i = 0; i < nw; i++) begin
      a = (b & ~32'd3) + 32'(4*i);
      eq.push_back('{1'b0, a, 32'd0, 4'd0});
      if (corrupt_en && a == corrupt_addr) exp_err = 1;
    end
    bq = src; wait_st = w; pct = p; done_cnt = 0; mv_seen = 0; sr_seen = 0;
    @(negedge clk);
    start = 1'b1; base_addr = b; len = LEN_W'(n);
    @(negedge clk);
    start = 1'b0; base_addr = $urandom; len = LEN_W'($urandom);
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic finish_xfer(input int lim);
    int t = 0;
    while (!done && t < lim) begin
      if (noise) begin
        start = ($urandom_range(7) == 0);
        base_addr = $urandom;
        len = LEN_W'($urandom);
      end
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("reqs_left", 32'(eq.size()), 32'd0);
    chk("bytes_left", 32'(bq.size()), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("ck_held", checksum, exp_ck);
    chk("err_held", 32'(err), 32'(exp_err));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n, nw;
    logic [31:0] b;
    repeat (3) @(negedge clk);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    src = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    kick(32'h100, 8, 0, 100);
    finish_xfer(200);
    chk("full_word0", rd_mem(32'h100), 32'h04030201);
    chk("full_word1", rd_mem(32'h104), 32'h08070605);
    chk("full_checksum", checksum, 32'h24);
    chk("full_err", 32'(err), 32'd0);

    corrupt_en = 1; corrupt_addr = 32'h104;
    kick(32'h100, 8, 0, 100);
    finish_xfer(200);
    chk("mismatch_err", 32'(err), 32'd1);
    corrupt_en = 0;

    mem[30'h80] = 32'h11111111;
    mem[30'h81] = 32'h99887766;
    src = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    kick(32'h203, 5, 0, 100);
    finish_xfer(200);
    chk("tail_word0", rd_mem(32'h200), 32'hDDCCBBAA);
    chk("tail_word1", rd_mem(32'h204), 32'h998877EE);
    chk("tail_checksum", checksum, 32'h3FC);

    src.delete();
    kick(32'h400, 0, 0, 100);
    finish_xfer(2);
    chk("len0_no_mem", 32'(mv_seen), 32'd0);
    chk("len0_no_sready", 32'(sr_seen), 32'd0);
    chk("len0_checksum", checksum, 32'd0);

    src.delete();
    for (int k = 0; k < 13; k++) src.push_back(8'($urandom));
    kick(32'h500, 13, 3, 40);
    finish_xfer(2000);

    src.delete();
    for (int k = 0; k < 8; k++) src.push_back(8'($urandom));
    kick(32'h600, 8, 5, 100);
    t = 0;
    while (!mem_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("wr_req_reached", 32'(mem_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_valid", 32'(mem_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_s_ready", 32'(s_ready), 32'd0);
    eq.delete(); bq.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);
    kick(32'h600, 8, 1, 70);
    finish_xfer(2000);

    noise = 1;
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(0, 40);
      b = $urandom;
      nw = (n + 3) / 4;
      src.delete();
      for (int k = 0; k < n; k++) src.push_back(8'($urandom));
      corrupt_en = (n > 0) && ($urandom_range(2) == 0);
      corrupt_addr = (n > 0) ? (b & ~32'd3) + 32'(4 * $urandom_range(0, nw - 1)) : 32'd0;
      kick(b, n, $urandom_range(0, 3), $urandom_range(30, 100));
      finish_xfer(n == 0 ? 2 : 20000);
    end
    noise = 0;
    corrupt_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
